biasrelu_seq: RTL and testbench

Sequencer for the bias/ReLU datapath. It runs a tile of `len` bus-width beats. For each beat it:

- reads one word from the source memory port;
- loads the word into the datapath and starts it;
- waits for the datapath's done;
- writes the result back to the destination address.

It also holds the datapath configuration (bias, mode, binary points, enables) stable for the whole tile. It sits between the Avalon-style read/write master adapters and the BiasReLU datapath instance in the accelerator top.

---
 rtl/biasrelu_pkg.sv | 30 +++
 rtl/biasrelu_seq.sv | 147 ++++++++++++++
 tb/tb_biasrelu_seq.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/biasrelu_pkg.sv
// Shared types and constants for the bias/ReLU tile sequencer.
package biasrelu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_START,
    ST_WAIT,
    ST_WR,
    ST_FIN
  } state_t;

  typedef struct packed {
    logic [31:0] bias;
    logic        relu_mod;
    logic [3:0]  data_bp;
    logic [3:0]  weight_bp;
    logic [3:0]  result_bp;
    logic        bias_en;
    logic        relu_en;
  } cfg_t;

  function automatic int beat_bytes(input int bus_width);
    return bus_width / 8;
  endfunction

  localparam int DEF_BUSWIDTH = 512;
  localparam int BEAT_BYTES   = beat_bytes(DEF_BUSWIDTH);

endpackage

// File: rtl/biasrelu_seq.sv
// Tile sequencer: read a beat, run it through the bias/ReLU datapath, write the
// result back, repeat for len beats. Datapath configuration is frozen per tile.
module biasrelu_seq
  import biasrelu_pkg::*;
#(
  parameter int BUSWIDTH = 512,
  parameter int AW       = 32,
  parameter int LW       = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [AW-1:0]       src_addr_i,
  input  logic [AW-1:0]       dst_addr_i,
  input  logic [LW-1:0]       len_i,
  input  logic [31:0]         cfg_bias_i,
  input  logic                cfg_relu_mod_i,
  input  logic [3:0]          cfg_data_bp_i,
  input  logic [3:0]          cfg_weight_bp_i,
  input  logic [3:0]          cfg_result_bp_i,
  input  logic                cfg_bias_en_i,
  input  logic                cfg_relu_en_i,
  output logic                rd_req_o,
  output logic [AW-1:0]       rd_addr_o,
  input  logic                rd_valid_i,
  input  logic [BUSWIDTH-1:0] rd_data_i,
  output logic                wr_req_o,
  output logic [AW-1:0]       wr_addr_o,
  output logic [BUSWIDTH-1:0] wr_data_o,
  input  logic                wr_ack_i,
  output logic [31:0]         bias_o,
  output logic                relu_mod_o,
  output logic [3:0]          data_bp_o,
  output logic [3:0]          weight_bp_o,
  output logic [3:0]          result_bp_o,
  output logic                bias_en_o,
  output logic                relu_en_o,
  output logic [BUSWIDTH-1:0] dp_data_o,
  output logic                dp_data_en_o,
  input  logic [BUSWIDTH-1:0] dp_result_i,
  output logic                br_start_o,
  input  logic                br_done_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                aborted_o,
  output logic [LW-1:0]       beats_left_o
);

  localparam logic [AW-1:0] STEP = AW'(beat_bytes(BUSWIDTH));

  state_t                state_q, state_d;
  cfg_t                  cfg_q;
  logic [AW-1:0]         rd_addr_q, wr_addr_q;
  logic [LW-1:0]         beats_q;
  logic [BUSWIDTH-1:0]   wr_data_q;
  logic                  zero_done_q;
  logic                  aborted_q;
  logic                  abort_hit;

  assign abort_hit = abort_i && (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    if (abort_hit) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start_i && (len_i != '0)) state_d = ST_RD;
        ST_RD:    if (rd_valid_i) state_d = ST_START;
        ST_START: state_d = ST_WAIT;
        ST_WAIT:  if (br_done_i) state_d = ST_WR;
        ST_WR:    if (wr_ack_i) state_d = (beats_q == LW'(1)) ? ST_FIN : ST_RD;
        ST_FIN:   state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cfg_q       <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      beats_q     <= '0;
      wr_data_q   <= '0;
      zero_done_q <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      zero_done_q <= 1'b0;
      aborted_q   <= abort_hit;
      if (!abort_hit) begin
        case (state_q)
          ST_IDLE: begin
            if (start_i && (len_i != '0)) begin
              cfg_q     <= '{bias: cfg_bias_i, relu_mod: cfg_relu_mod_i,
                             data_bp: cfg_data_bp_i, weight_bp: cfg_weight_bp_i,
                             result_bp: cfg_result_bp_i, bias_en: cfg_bias_en_i,
                             relu_en: cfg_relu_en_i};
              rd_addr_q <= src_addr_i;
              wr_addr_q <= dst_addr_i;
              beats_q   <= len_i;
            end else if (start_i) begin
              zero_done_q <= 1'b1;
            end
          end
          ST_WAIT: if (br_done_i) wr_data_q <= dp_result_i;
          ST_WR: begin
            // Addresses wrap modulo 2^AW by plain overflow.
            if (wr_ack_i) begin
              rd_addr_q <= rd_addr_q + STEP;
              wr_addr_q <= wr_addr_q + STEP;
              beats_q   <= beats_q - LW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Requests are level: held with stable address/data until rd_valid_i / wr_ack_i.
  assign rd_req_o     = (state_q == ST_RD);
  assign wr_req_o     = (state_q == ST_WR);
  assign br_start_o   = (state_q == ST_START);
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_FIN) || zero_done_q;
  assign aborted_o    = aborted_q;
  assign rd_addr_o    = rd_addr_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign beats_left_o = beats_q;

  assign dp_data_o    = rd_data_i;
  assign dp_data_en_o = rd_req_o && rd_valid_i && !abort_i;

  assign bias_o       = cfg_q.bias;
  assign relu_mod_o   = cfg_q.relu_mod;
  assign data_bp_o    = cfg_q.data_bp;
  assign weight_bp_o  = cfg_q.weight_bp;
  assign result_bp_o  = cfg_q.result_bp;
  assign bias_en_o    = cfg_q.bias_en;
  assign relu_en_o    = cfg_q.relu_en;

endmodule

// File: tb/tb_biasrelu_seq.sv
// Directed-plus-random bench for biasrelu_seq with memory/datapath responders.
module tb_biasrelu_seq;

  localparam int BW = 512;
  localparam int AW = 32;
  localparam int LW = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start_i = 1'b0, abort_i = 1'b0;
  logic [AW-1:0] src_addr_i = '0, dst_addr_i = '0;
  logic [LW-1:0] len_i = '0;
  logic [31:0] cfg_bias_i = '0;
  logic cfg_relu_mod_i = 1'b0, cfg_bias_en_i = 1'b0, cfg_relu_en_i = 1'b0;
  logic [3:0] cfg_data_bp_i = '0, cfg_weight_bp_i = '0, cfg_result_bp_i = '0;
  logic rd_req_o, rd_valid_i = 1'b0;
  logic [AW-1:0] rd_addr_o, wr_addr_o;
  logic [BW-1:0] rd_data_i = '0, wr_data_o, dp_data_o, dp_result_i;
  logic wr_req_o, wr_ack_i = 1'b0;
  logic [31:0] bias_o;
  logic relu_mod_o, bias_en_o, relu_en_o, dp_data_en_o, br_start_o;
  logic br_done_i = 1'b0;
  logic [3:0] data_bp_o, weight_bp_o, result_bp_o;
  logic busy_o, done_o, aborted_o;
  logic [LW-1:0] beats_left_o;

  biasrelu_seq #(.BUSWIDTH(BW), .AW(AW), .LW(LW)) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .abort_i(abort_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
    .cfg_bias_i(cfg_bias_i), .cfg_relu_mod_i(cfg_relu_mod_i),
    .cfg_data_bp_i(cfg_data_bp_i), .cfg_weight_bp_i(cfg_weight_bp_i),
    .cfg_result_bp_i(cfg_result_bp_i), .cfg_bias_en_i(cfg_bias_en_i),
    .cfg_relu_en_i(cfg_relu_en_i),
    .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o), .rd_valid_i(rd_valid_i),
    .rd_data_i(rd_data_i),
    .wr_req_o(wr_req_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .wr_ack_i(wr_ack_i),
    .bias_o(bias_o), .relu_mod_o(relu_mod_o), .data_bp_o(data_bp_o),
    .weight_bp_o(weight_bp_o), .result_bp_o(result_bp_o),
    .bias_en_o(bias_en_o), .relu_en_o(relu_en_o),
    .dp_data_o(dp_data_o), .dp_data_en_o(dp_data_en_o),
    .dp_result_i(dp_result_i), .br_start_o(br_start_o), .br_done_i(br_done_i),
    .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o),
    .beats_left_o(beats_left_o)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed event missing or unexpected, expected otherwise", tag);
  endtask

  // ---------------- reference model state ----------------
  logic [AW-1:0] exp_rd_q[$];
  logic [AW-1:0] exp_wa_q[$];
  logic [BW-1:0] exp_wd_q[$];
  int tile_len = 0, beat_idx = 0, starts = 0, done_cnt = 0;
  int last_ack_cyc = 0, first_rd_cyc = 0;
  logic [31:0] exp_bias = '0;
  logic [3:0]  exp_dbp = '0, exp_wbp = '0, exp_rbp = '0;
  logic        exp_mod = 1'b0, exp_ben = 1'b0, exp_ren = 1'b0;

  // Stand-in datapath: any fixed bijection works, the sequencer only moves words.
  function automatic logic [BW-1:0] dp_model(input logic [BW-1:0] w);
    return {w[BW-2:0], w[BW-1]} ^ {16{32'hA5A5_5A5A}};
  endfunction

  function automatic logic [BW-1:0] rand_word();
    logic [BW-1:0] w;
    for (int i = 0; i < BW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  logic [BW-1:0] dp_latch = '0;
  assign dp_result_i = dp_model(dp_latch);

  // ---------------- responders (memory + datapath done) ----------------
  int rd_dly = 1, done_dly = 0, ack_dly = 0;
  int rcnt = 0, wcnt = 0, acnt = 0;
  bit in_wait = 1'b0;

  initial forever begin
    @(posedge clk);
    #1;
    rd_valid_i = 1'b0;
    br_done_i  = 1'b0;
    wr_ack_i   = 1'b0;
    if (!rstn) begin
      rcnt = 0; acnt = 0; in_wait = 1'b0;
    end else begin
      if (rd_req_o) begin
        rcnt++;
        if (rcnt > rd_dly) begin
          rd_valid_i = 1'b1;
          rd_data_i  = rand_word();
          exp_wd_q.push_back(dp_model(rd_data_i));
        end
      end else begin
        rcnt = 0;
      end
      if (br_start_o) begin
        in_wait = 1'b1;
        wcnt = 0;
      end else if (in_wait) begin
        wcnt++;
        if (wcnt > done_dly) begin
          br_done_i = 1'b1;
          in_wait = 1'b0;
        end
      end
      if (wr_req_o) begin
        acnt++;
        wr_ack_i = (acnt > ack_dly);
      end else begin
        acnt = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic prev_rd_req = 1'b0, prev_wr_req = 1'b0, prev_br_start = 1'b0;
  logic [AW-1:0] prev_rd_addr = '0, prev_wr_addr = '0;
  logic [BW-1:0] prev_wr_data = '0;

  initial forever begin
    @(negedge clk);
    if (rstn) begin
      chk("dp_en_follows_valid", BW'(dp_data_en_o), BW'(rd_valid_i));
      if (rd_req_o && prev_rd_req) chk("rd_addr_stable", BW'(rd_addr_o), BW'(prev_rd_addr));
      if (wr_req_o && prev_wr_req) begin
        chk("wr_addr_stable", BW'(wr_addr_o), BW'(prev_wr_addr));
        chk("wr_data_stable", wr_data_o, prev_wr_data);
      end
      if (br_start_o) begin
        starts++;
        chk("br_start_single", BW'(prev_br_start), BW'(1'b0));
      end
      if (rd_req_o && rd_valid_i) begin
        if (exp_rd_q.size() == 0) fail_now("rd_unexpected");
        else chk("rd_addr", BW'(rd_addr_o), BW'(exp_rd_q.pop_front()));
        chk("dp_data", dp_data_o, rd_data_i);
        chk("beats_left", BW'(beats_left_o), BW'(tile_len - beat_idx));
        dp_latch = dp_data_o;
      end
      if (wr_req_o && wr_ack_i) begin
        if (exp_wa_q.size() == 0 || exp_wd_q.size() == 0) fail_now("wr_unexpected");
        else begin
          chk("wr_addr", BW'(wr_addr_o), BW'(exp_wa_q.pop_front()));
          chk("wr_data", wr_data_o, exp_wd_q.pop_front());
        end
        beat_idx++;
        last_ack_cyc = cyc;
      end
      if (done_o) done_cnt++;
    end
    prev_rd_req   = rd_req_o;
    prev_wr_req   = wr_req_o;
    prev_br_start = br_start_o;
    prev_rd_addr  = rd_addr_o;
    prev_wr_addr  = wr_addr_o;
    prev_wr_data  = wr_data_o;
  end

  // ---------------- driver tasks ----------------
  task automatic rand_cfg_inputs();
    cfg_bias_i      = $urandom;
    cfg_relu_mod_i  = 1'($urandom_range(0, 1));
    cfg_data_bp_i   = 4'($urandom_range(0, 15));
    cfg_weight_bp_i = 4'($urandom_range(0, 15));
    cfg_result_bp_i = 4'($urandom_range(0, 15));
    cfg_bias_en_i   = 1'($urandom_range(0, 1));
    cfg_relu_en_i   = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_model();
    exp_rd_q.delete();
    exp_wa_q.delete();
    exp_wd_q.delete();
  endtask

  task automatic begin_tile(input logic [AW-1:0] src, input logic [AW-1:0] dst, input int len,
                            input int rdl, input int dnl, input int akl);
    logic [AW-1:0] a;
    rd_dly = rdl; done_dly = dnl; ack_dly = akl;
    tile_len = len; beat_idx = 0; starts = 0;
    for (int i = 0; i < len; i++) begin
      a = src + AW'(64 * i);
      exp_rd_q.push_back(a);
      a = dst + AW'(64 * i);
      exp_wa_q.push_back(a);
    end
    rand_cfg_inputs();
    exp_bias = cfg_bias_i; exp_mod = cfg_relu_mod_i; exp_dbp = cfg_data_bp_i;
    exp_wbp = cfg_weight_bp_i; exp_rbp = cfg_result_bp_i;
    exp_ben = cfg_bias_en_i; exp_ren = cfg_relu_en_i;
    @(posedge clk); #1;
    start_i = 1'b1; src_addr_i = src; dst_addr_i = dst; len_i = LW'(len);
    @(posedge clk); #1;
    start_i = 1'b0;
    rand_cfg_inputs();
    src_addr_i = $urandom; dst_addr_i = $urandom; len_i = LW'($urandom_range(0, 9));
    @(negedge clk);
    first_rd_cyc = cyc;
    chk("first_rd_req", BW'(rd_req_o), BW'(1'b1));
    chk("busy_after_start", BW'(busy_o), BW'(1'b1));
    chk("beats_left_start", BW'(beats_left_o), BW'(len));
  endtask

  task automatic finish_tile(input int span);
    int k;
    k = 0;
    while (!done_o && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (!done_o) begin
      fail_now("done_timeout");
    end else begin
      chk("done_after_last_ack", BW'(cyc - last_ack_cyc), BW'(1));
      if (span >= 0) chk("tile_span", BW'(cyc - first_rd_cyc), BW'(span));
      chk("beats_done", BW'(beat_idx), BW'(tile_len));
      chk("one_start_per_beat", BW'(starts), BW'(tile_len));
      chk("rd_queue_empty", BW'(exp_rd_q.size()), BW'(0));
      chk("wr_queue_empty", BW'(exp_wa_q.size()), BW'(0));
      chk("beats_left_end", BW'(beats_left_o), BW'(0));
      chk("bias_o", BW'(bias_o), BW'(exp_bias));
      chk("cfg_misc", BW'({relu_mod_o, data_bp_o, weight_bp_o, result_bp_o, bias_en_o, relu_en_o}),
          BW'({exp_mod, exp_dbp, exp_wbp, exp_rbp, exp_ben, exp_ren}));
      @(negedge clk);
      chk("done_single", BW'(done_o), BW'(1'b0));
      chk("busy_after_fin", BW'(busy_o), BW'(1'b0));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, BW'({busy_o, rd_req_o, wr_req_o, br_start_o, done_o, aborted_o, dp_data_en_o}),
        BW'(7'd0));
    chk({tag, "_addr"}, BW'({rd_addr_o, wr_addr_o}), BW'(64'd0));
    chk({tag, "_wr_data"}, wr_data_o, BW'(0));
    chk({tag, "_beats_left"}, BW'(beats_left_o), BW'(0));
    chk({tag, "_cfg"}, BW'({bias_o, relu_mod_o, data_bp_o, weight_bp_o, result_bp_o, bias_en_o, relu_en_o}),
        BW'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    int d0;
    logic [31:0] keep_bias;
    logic [AW-1:0] s, d;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rstn = 1'b1;

    // Three-beat tile, immediate responses
    begin_tile(32'h0000_1000, 32'h0000_2000, 3, 1, 0, 0);
    finish_tile(15);

    // Zero-length start: lone done pulse, config untouched
    d0 = done_cnt;
    @(posedge clk); #1;
    rand_cfg_inputs();
    start_i = 1'b1; len_i = '0;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    chk("len0_done", BW'(done_o), BW'(1'b1));
    chk("len0_busy", BW'(busy_o), BW'(1'b0));
    chk("len0_no_rd", BW'(rd_req_o), BW'(1'b0));
    @(negedge clk);
    chk("len0_done_single", BW'(done_cnt - d0), BW'(1));
    chk("len0_busy_after", BW'(busy_o), BW'(1'b0));
    chk("len0_bias_kept", BW'(bias_o), BW'(exp_bias));

    // Stalled handshakes, two beats
    s = {$urandom_range(0, 32'h03FF_FFFF), 6'd0};
    d = {$urandom_range(0, 32'h03FF_FFFF), 6'd0};
    begin_tile(s, d, 2, 5, 3, 6);
    finish_tile(36);

    // Address wrap
    begin_tile(32'hFFFF_FFC0, 32'hFFFF_FF80, 2, 1, 0, 0);
    finish_tile(10);

    // Start while busy is ignored
    begin_tile(32'h0000_4000, 32'h0000_8000, 3, 2, 2, 2);
    keep_bias = exp_bias;
    repeat (4) @(posedge clk);
    #1;
    rand_cfg_inputs();
    cfg_bias_i = ~keep_bias;
    start_i = 1'b1; len_i = LW'(5); src_addr_i = 32'h0000_C000;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    finish_tile(-1);
    chk("busy_start_bias_kept", BW'(bias_o), BW'(keep_bias));

    // Abort in WAIT with br_done coincident
    begin_tile(32'h0001_0000, 32'h0002_0000, 2, 1, 0, 0);
    k = 0;
    while (!br_start_o && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!br_start_o) begin
      fail_now("abort_start_timeout");
    end else begin
      d0 = done_cnt;
      @(posedge clk); #1;
      abort_i = 1'b1;
      chk("abort_coincident_done", BW'(br_done_i), BW'(1'b1));
      @(posedge clk); #1;
      abort_i = 1'b0;
      @(negedge clk);
      chk("aborted_pulse", BW'(aborted_o), BW'(1'b1));
      chk("abort_idle", BW'(busy_o), BW'(1'b0));
      chk("abort_no_wr", BW'(wr_req_o), BW'(1'b0));
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("abort_quiet", BW'({aborted_o, wr_req_o, rd_req_o, busy_o}), BW'(4'd0));
      end
      chk("abort_no_done", BW'(done_cnt - d0), BW'(0));
    end
    clear_model();

    // Reset in the middle of a write
    begin_tile(32'h0003_0000, 32'h0004_0000, 2, 1, 0, 6);
    k = 0;
    while (!wr_req_o && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!wr_req_o) fail_now("wr_req_timeout");
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("mid_reset");
    @(posedge clk); #1;
    rstn = 1'b1;
    clear_model();
    begin_tile(32'h0005_0000, 32'h0006_0000, 2, 1, 0, 0);
    finish_tile(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case a wait loop above is ever broken.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
